hid_key_event: RTL and testbench
================================

Name: hid_key_event

Overview:
- Sits directly downstream of ukp2key, in the usbclk domain.
- Takes each completed 8-byte HID boot-keyboard report (modifier byte key0, keycodes key1..key6), marked by a toggle on new_packet, and diffs it against the previous accepted report.
- Emits one make/break event per changed key into a FWFT FIFO with a valid/ready read port for the keyboard-matrix / CPU side.
- Also exports the current modifier state.

Parameters:
- FIFO_DEPTH, 16, event FIFO entries; power of two, minimum 4.
- ROLLOVER_CODE, 8'h01, HID ErrorRollOver usage; a report containing it is discarded.

Ports:
- usbclk  in  1  12 MHz clock; the block's only clock.
- usbrst  in  1  reset, asynchronous, active-high.
- key0  in  8  modifier bits from ukp2key.
- key1..key6  in  8 each  keycode slots from ukp2key.
- new_packet  in  1  toggles once per completed report.
- conerr  in  1  connection error / watchdog from ukp2key.
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  HID usage of the head event; modifiers are 8'hE0+bit.
- ev_make  out  1  1 = press, 0 = release.
- ev_ready  in  1  consumer accepts the head event.
- overflow  out  1  sticky; a report was dropped.
- cur_mods  out  8  modifier byte of the last committed report.

Behaviour:
- **Reset:** ev_valid=0, overflow=0, cur_mods=0, previous-report registers (pmod, pk1..pk6) = 0, FIFO empty, FSM=IDLE, pending=0, arm=0.
- **Toggle detection:**
  - On the first cycle after reset, np_d <= new_packet and arm <= 1; no detection occurs that cycle (new_packet has no reset upstream).
  - After that, any new_packet != np_d is one report event.
- **Snapshot:** all seven key bytes are captured into nmod/nk1..nk6 in the detection cycle.
- **Report arriving while FSM != IDLE:** captured into a single pending buffer and pending=1. A further report while pending=1 overwrites the buffer and sets overflow=1.
- **Rollover filter:** at capture, if any nk == ROLLOVER_CODE, the report is discarded; no events are generated and pmod/pk are unchanged.
- **FSM (one compare per cycle; a cycle holds while a push is needed and the FIFO is full — events are never lost):**
  - IDLE: on a snapshot (direct, or pending with pending cleared) -> MODS, index=0.
  - MODS (8 cycles, bit 0..7): if nmod[i]!=pmod[i], push {8'hE0+i, nmod[i]}.
  - REL (slots 1..6): if pk[i]!=0 and pk[i] is absent from nk1..nk6, push {pk[i], 0}.
  - PRS (slots 1..6): if nk[i]!=0, nk[i] is absent from pk1..pk6, and nk[i] is not equal to any nk[j] with j<i, push {nk[i], 1}.
  - COMMIT (1 cycle): pmod<=nmod, pk<=nk, cur_mods<=nmod -> IDLE.
- **Timing:**
  - Unstalled scan is exactly 21 cycles: MODS 8 + REL 6 + PRS 6 + COMMIT 1.
  - A push in cycle C makes the event visible on ev_valid at C+1.
  - Event order is modifiers bit0->7, then releases slot1->6, then presses slot1->6.
- **FIFO:**
  - FWFT; ev_code/ev_make are the head entry.
  - Pop when ev_valid && ev_ready.
  - Simultaneous push and pop when full is allowed (count unchanged).
  - Pointers wrap modulo FIFO_DEPTH.
- **conerr:**
  - Rising edge of conerr while FSM=IDLE injects an all-zero snapshot, which releases every held key and modifier.
  - If the rising edge occurs while busy, the injection takes the pending slot (overflow=1 if it displaces a report).
  - While conerr=1, new_packet toggles are ignored but np_d still tracks, and any real pending report is cleared.
- **overflow:** cleared only by reset.

Test Plan:
- Reset, then report mods=0x00, k1=0x04 -> exactly one event {0x04,make}; cur_mods=0x00 after 21 cycles.
- Then report mods=0x02, k1=0x05 -> events {0xE1,1}, {0x04,0}, {0x05,1} in that order.
- Report with k1=k2=0x06 -> single {0x06,1}. Next report containing 0x01 in k3 -> no events, pk unchanged.
- ev_ready=0, 24 key changes across reports with FIFO_DEPTH=16 -> FSM stalls at full, ev_valid held. Release ev_ready -> all events drain in order, none lost.
- Three toggles 2 cycles apart during one scan -> second report dropped, overflow=1, only third report diffed after the first.
- Keys 0x04 and LShift held, conerr 0->1 -> {0xE1,0}, {0x04,0}. Toggles while conerr=1 produce nothing. usbrst asserted mid-scan -> outputs return to reset values immediately.

Source files
------------

// File: rtl/hid_key_event.sv
// rtl/hid_key_event.sv - HID boot-keyboard report differ producing make/break events
//
// Purpose: each completed 8-byte boot report (marked by a toggle on new_packet)
// is compared with the previously committed report. One event per changed key
// is pushed into a first-word-fall-through FIFO read with valid/ready.
//
// Ports:
//   usbclk      in   1  block clock (12 MHz)
//   usbrst      in   1  asynchronous active-high reset
//   key0        in   8  modifier byte
//   key1..key6  in   8  keycode slots
//   new_packet  in   1  toggles once per completed report
//   conerr      in   1  connection error; rising edge releases everything held
//   ev_valid    out  1  event FIFO non-empty
//   ev_code     out  8  usage of head event (modifiers are 8'hE0 + bit)
//   ev_make     out  1  1 = press, 0 = release
//   ev_ready    in   1  consumer takes the head event
//   overflow    out  1  sticky: a buffered report was displaced
//   cur_mods    out  8  modifier byte of the last committed report
`timescale 1ns/1ps
module hid_key_event #(
  parameter int         FIFO_DEPTH    = 16,
  parameter logic [7:0] ROLLOVER_CODE = 8'h01
) (
  input  logic       usbclk,
  input  logic       usbrst,
  input  logic [7:0] key0,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] key4,
  input  logic [7:0] key5,
  input  logic [7:0] key6,
  input  logic       new_packet,
  input  logic       conerr,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_make,
  input  logic       ev_ready,
  output logic       overflow,
  output logic [7:0] cur_mods
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_MODS, S_REL, S_PRS, S_COMMIT} state_t;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic          r_arm;
  logic          r_np_d;
  logic          r_conerr_d;
  logic [7:0]    r_nmod;
  logic [7:0]    r_pmod;
  logic [7:0]    r_nk [6];
  logic [7:0]    r_pk [6];
  logic          r_pend;
  logic          r_pend_inj;
  logic [7:0]    r_pend_mod;
  logic [7:0]    r_pend_k [6];
  logic          r_overflow;
  logic [7:0]    r_cur_mods;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic [7:0]    w_in_k [6];
  logic [7:0]    w_snap_k [6];
  logic [7:0]    w_snap_mod;
  logic          w_toggle;
  logic          w_roll;
  logic          w_cerr_rise;
  logic          w_snap;
  logic          w_push_req;
  logic [7:0]    w_push_code;
  logic          w_push_make;
  logic          w_hit;
  logic          w_dup;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_stall;

  // Incoming snapshot: a real report (not during conerr, not rollover) or an
  // all-zero injection on the conerr rising edge.
  always_comb begin
    w_in_k[0] = key1;
    w_in_k[1] = key2;
    w_in_k[2] = key3;
    w_in_k[3] = key4;
    w_in_k[4] = key5;
    w_in_k[5] = key6;
    w_toggle    = r_arm && (new_packet != r_np_d);
    w_cerr_rise = conerr && !r_conerr_d;
    w_roll      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_in_k[i] == ROLLOVER_CODE) w_roll = 1'b1;
      w_snap_k[i] = w_cerr_rise ? 8'h00 : w_in_k[i];
    end
    w_snap_mod = w_cerr_rise ? 8'h00 : key0;
    w_snap     = (w_toggle && !conerr && !w_roll) || w_cerr_rise;
  end

  // One comparison per scan cycle; decides whether this cycle needs a push.
  always_comb begin
    w_push_req  = 1'b0;
    w_push_code = 8'h00;
    w_push_make = 1'b0;
    w_hit       = 1'b0;
    w_dup       = 1'b0;
    case (r_state)
      S_MODS: begin
        if (r_nmod[r_idx] != r_pmod[r_idx]) begin
          w_push_req  = 1'b1;
          w_push_code = 8'hE0 | {5'd0, r_idx};
          w_push_make = r_nmod[r_idx];
        end
      end
      S_REL: begin
        for (int j = 0; j < 6; j++)
          if (r_nk[j] == r_pk[r_idx]) w_hit = 1'b1;
        if (r_pk[r_idx] != 8'h00 && !w_hit) begin
          w_push_req  = 1'b1;
          w_push_code = r_pk[r_idx];
        end
      end
      S_PRS: begin
        for (int j = 0; j < 6; j++) begin
          if (r_pk[j] == r_nk[r_idx]) w_hit = 1'b1;
          // a code repeated in the same report is pressed only once
          if (3'(j) < r_idx && r_nk[j] == r_nk[r_idx]) w_dup = 1'b1;
        end
        if (r_nk[r_idx] != 8'h00 && !w_hit && !w_dup) begin
          w_push_req  = 1'b1;
          w_push_code = r_nk[r_idx];
          w_push_make = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_valid = (r_cnt != '0);
    w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    w_pop   = w_valid && ev_ready;
    w_push  = w_push_req && (!w_full || w_pop);
    w_stall = w_push_req && !w_push;
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge usbclk) begin
    if (w_push) r_mem[r_wp] <= {w_push_code, w_push_make};
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_arm      <= 1'b0;
      r_np_d     <= 1'b0;
      r_conerr_d <= 1'b0;
      r_nmod     <= 8'h00;
      r_pmod     <= 8'h00;
      r_pend     <= 1'b0;
      r_pend_inj <= 1'b0;
      r_pend_mod <= 8'h00;
      r_overflow <= 1'b0;
      r_cur_mods <= 8'h00;
      for (int i = 0; i < 6; i++) begin
        r_nk[i]     <= 8'h00;
        r_pk[i]     <= 8'h00;
        r_pend_k[i] <= 8'h00;
      end
    end else begin
      // new_packet has no reset upstream, so the first cycle only samples it
      r_arm      <= 1'b1;
      r_np_d     <= new_packet;
      r_conerr_d <= conerr;
      case (r_state)
        S_IDLE: begin
          r_idx <= 3'd0;
          if (r_pend) begin
            r_nmod  <= r_pend_mod;
            r_nk    <= r_pend_k;
            r_state <= S_MODS;
            r_pend  <= w_snap;
            if (w_snap) begin
              r_pend_mod <= w_snap_mod;
              r_pend_k   <= w_snap_k;
              r_pend_inj <= w_cerr_rise;
            end
          end else if (w_snap) begin
            r_nmod  <= w_snap_mod;
            r_nk    <= w_snap_k;
            r_state <= S_MODS;
          end
        end
        default: begin
          if (w_snap) begin
            r_pend     <= 1'b1;
            r_pend_mod <= w_snap_mod;
            r_pend_k   <= w_snap_k;
            r_pend_inj <= w_cerr_rise;
            if (r_pend) r_overflow <= 1'b1;
          end else if (conerr && r_pend && !r_pend_inj) begin
            r_pend <= 1'b0;
          end
          case (r_state)
            S_MODS: if (!w_stall) begin
              if (r_idx == 3'd7) begin
                r_state <= S_REL;
                r_idx   <= 3'd0;
              end else r_idx <= r_idx + 3'd1;
            end
            S_REL: if (!w_stall) begin
              if (r_idx == 3'd5) begin
                r_state <= S_PRS;
                r_idx   <= 3'd0;
              end else r_idx <= r_idx + 3'd1;
            end
            S_PRS: if (!w_stall) begin
              if (r_idx == 3'd5) r_state <= S_COMMIT;
              else r_idx <= r_idx + 3'd1;
            end
            default: begin
              r_pmod     <= r_nmod;
              r_pk       <= r_nk;
              r_cur_mods <= r_nmod;
              r_state    <= S_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  assign ev_valid = w_valid;
  assign ev_code  = r_mem[r_rp][8:1];
  assign ev_make  = r_mem[r_rp][0];
  assign overflow = r_overflow;
  assign cur_mods = r_cur_mods;

endmodule

// File: tb/tb_hid_key_event.sv
// tb/tb_hid_key_event.sv - self-checking bench for hid_key_event
`timescale 1ns/1ps
module tb_hid_key_event;

  logic       usbclk = 1'b0;
  logic       usbrst = 1'b1;
  logic [7:0] key0, key1, key2, key3, key4, key5, key6;
  logic       new_packet, conerr, ev_ready;
  logic       ev_valid, ev_make, overflow;
  logic [7:0] ev_code, cur_mods;

  always #5 usbclk = ~usbclk;

  hid_key_event #(.FIFO_DEPTH(16), .ROLLOVER_CODE(8'h01)) dut (
    .usbclk(usbclk), .usbrst(usbrst),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3),
    .key4(key4), .key5(key5), .key6(key6),
    .new_packet(new_packet), .conerr(conerr),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_make(ev_make),
    .ev_ready(ev_ready), .overflow(overflow), .cur_mods(cur_mods)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] m_pmod;
  logic [7:0] m_pk [6];
  bit         rnd_ready = 1'b0;

  typedef struct {
    logic [7:0]  mod;
    logic [47:0] keys;   // slot1 in [7:0] ... slot6 in [47:40]
    int          n;
    logic [8:0]  ev [4];
    logic [7:0]  mods_after;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [8:0] ev(input logic [7:0] code, input logic make);
    return {code, make};
  endfunction

  always @(negedge usbclk)
    if (!usbrst && ev_valid && ev_ready) got_q.push_back({ev_code, ev_make});

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge usbclk);
    #1;
    if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: events implied by going from the model's previous report to this one.
  task automatic model_apply(input logic [7:0] mod, input logic [47:0] keys);
    logic [7:0] nk [6];
    bit roll, found, seen;
    roll = 0;
    for (int i = 0; i < 6; i++) begin
      nk[i] = keys[8*i +: 8];
      if (nk[i] == 8'h01) roll = 1;
    end
    if (!roll) begin
      for (int b = 0; b < 8; b++)
        if (mod[b] != m_pmod[b]) exp_q.push_back(ev(8'hE0 + 8'(b), mod[b]));
      for (int i = 0; i < 6; i++) begin
        found = 0;
        foreach (nk[j]) if (nk[j] == m_pk[i]) found = 1;
        if (m_pk[i] != 0 && !found) exp_q.push_back(ev(m_pk[i], 1'b0));
      end
      for (int i = 0; i < 6; i++) begin
        found = 0;
        seen  = 0;
        foreach (m_pk[j]) if (m_pk[j] == nk[i]) found = 1;
        for (int j = 0; j < i; j++) if (nk[j] == nk[i]) seen = 1;
        if (nk[i] != 0 && !found && !seen) exp_q.push_back(ev(nk[i], 1'b1));
      end
      m_pmod = mod;
      foreach (nk[i]) m_pk[i] = nk[i];
    end
  endtask

  task automatic raw_toggle(input logic [7:0] mod, input logic [47:0] keys);
    key0 = mod;
    {key6, key5, key4, key3, key2, key1} = keys;
    new_packet = ~new_packet;
  endtask

  task automatic send(input logic [7:0] mod, input logic [47:0] keys);
    raw_toggle(mod, keys);
    model_apply(mod, keys);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=%0d required=%0d", name, got_q.size(), exp_q.size());
    end
    repeat (25) tick();
  endtask

  task automatic compare_q(input string name);
    int m;
    chk({name, " count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s ev%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_vec(input int i, input logic [7:0] mod, input logic [47:0] keys, input int n,
                         input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                         input logic [8:0] e3, input logic [7:0] ma);
    vecs[i].mod = mod;
    vecs[i].keys = keys;
    vecs[i].n = n;
    vecs[i].ev[0] = e0;
    vecs[i].ev[1] = e1;
    vecs[i].ev[2] = e2;
    vecs[i].ev[3] = e3;
    vecs[i].mods_after = ma;
  endtask

  initial begin
    logic [7:0]  rmod;
    logic [47:0] rkeys;
    int          r;

    set_vec(0, 8'h00, 48'h000000000004, 1, ev(8'h04,1), 9'h0, 9'h0, 9'h0, 8'h00);
    set_vec(1, 8'h02, 48'h000000000005, 3, ev(8'hE1,1), ev(8'h04,0), ev(8'h05,1), 9'h0, 8'h02);
    set_vec(2, 8'h02, 48'h000000060605, 1, ev(8'h06,1), 9'h0, 9'h0, 9'h0, 8'h02);
    set_vec(3, 8'h00, 48'h000000010605, 0, 9'h0, 9'h0, 9'h0, 9'h0, 8'h02);
    set_vec(4, 8'h00, 48'h000000000006, 2, ev(8'hE1,0), ev(8'h05,0), 9'h0, 9'h0, 8'h00);
    set_vec(5, 8'h81, 48'h040000000000, 4, ev(8'hE0,1), ev(8'hE7,1), ev(8'h06,0), ev(8'h04,1), 8'h81);

    {key0, key1, key2, key3, key4, key5, key6} = '0;
    new_packet = 0;
    conerr = 0;
    ev_ready = 1;
    m_pmod = 0;
    foreach (m_pk[i]) m_pk[i] = 0;

    repeat (3) @(posedge usbclk);
    #1 usbrst = 0;
    repeat (3) tick();
    chk("rst ev_valid", ev_valid, 0);
    chk("rst overflow", overflow, 0);
    chk("rst cur_mods", cur_mods, 0);

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].mod, vecs[v].keys);
      exp_q.delete();
      for (int e = 0; e < vecs[v].n; e++) exp_q.push_back(vecs[v].ev[e]);
      wait_done($sformatf("vec%0d", v));
      compare_q($sformatf("vec%0d", v));
      chk($sformatf("vec%0d cur_mods", v), cur_mods, vecs[v].mods_after);
    end

    // FIFO full: the scan must stall, keep everything and not commit early.
    ev_ready = 0;
    send(8'hFF, 48'h151413121110);
    repeat (30) tick();
    send(8'h00, 48'h252423222120);
    repeat (60) tick();
    chk("stall ev_valid", ev_valid, 1);
    chk("stall cur_mods", cur_mods, 8'hFF);
    chk("stall no pops", got_q.size(), 0);
    ev_ready = 1;
    wait_done("stall");
    chk("stall total", exp_q.size(), 33);
    compare_q("stall");
    chk("stall cur_mods after", cur_mods, 8'h00);

    // Three reports during one scan: the middle one is displaced.
    chk("ovf before", overflow, 0);
    send(8'h00, 48'h000000000004);
    tick(); tick();
    raw_toggle(8'h00, 48'h000000000005);
    tick(); tick();
    send(8'h01, 48'h000000000604);
    wait_done("ovf");
    compare_q("ovf");
    chk("ovf sticky", overflow, 1);

    // conerr releases everything; toggles while it is high are ignored.
    send(8'h02, 48'h000000000004);
    wait_done("pre conerr");
    compare_q("pre conerr");
    conerr = 1;
    model_apply(8'h00, 48'h0);
    wait_done("conerr");
    compare_q("conerr");
    raw_toggle(8'h00, 48'h000000000007);
    tick(); tick(); tick();
    raw_toggle(8'h00, 48'h000000000807);
    repeat (30) tick();
    chk("conerr ignore", got_q.size(), 0);
    conerr = 0;
    repeat (10) tick();
    chk("conerr fall quiet", got_q.size(), 0);
    chk("conerr cur_mods", cur_mods, 8'h00);

    // Randomised reports with a randomly stalling consumer.
    rnd_ready = 1;
    for (int it = 0; it < 30; it++) begin
      rmod = 8'($urandom);
      for (int s = 0; s < 6; s++) begin
        r = $urandom_range(0, 9);
        rkeys[8*s +: 8] = (r < 3) ? 8'h00 : 8'h04 + 8'(r % 5);
      end
      if ($urandom_range(0, 7) == 0) rkeys[23:16] = 8'h01;
      send(rmod, rkeys);
      wait_done($sformatf("rnd%0d", it));
      compare_q($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d cur_mods", it), cur_mods, m_pmod);
    end
    rnd_ready = 0;
    ev_ready = 1;

    // Reset in the middle of a scan clears outputs at once.
    send(8'h04, 48'h000000000009);
    repeat (5) tick();
    usbrst = 1;
    #1;
    chk("midrst ev_valid", ev_valid, 0);
    chk("midrst overflow", overflow, 0);
    chk("midrst cur_mods", cur_mods, 0);
    repeat (3) tick();
    usbrst = 0;
    got_q.delete();
    exp_q.delete();
    m_pmod = 0;
    foreach (m_pk[i]) m_pk[i] = 0;
    repeat (3) tick();
    send(8'h00, 48'h000000000004);
    wait_done("post rst");
    compare_q("post rst");
    chk("post rst cur_mods", cur_mods, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
